// File: rtl/event_stamper_pkg.sv
// Shared event-word layout and event codes for the reporter/stamper pipeline.
package event_stamper_pkg;

    localparam int EVT_WIDTH      = 256;
    localparam int EVT_CODE_LSB   = 0;
    localparam int EVT_CODE_W     = 8;
    localparam int EVT_SEQ_LSB    = 16;
    localparam int EVT_SEQ_W      = 32;
    localparam int EVT_TS_LSB     = 48;
    localparam int EVT_TS_W       = 64;
    localparam int EVT_MARKER_LSB = 248;
    localparam int EVT_MARKER_W   = 8;

    localparam logic [7:0] MARKER_VALUE = 8'h01;

    typedef enum logic [7:0] {
        EVT_UNDERFLOW = 8'h01,
        EVT_A         = 8'h02,
        EVT_B         = 8'h03
    } evt_code_e;

    // Builds a stamped event word; every bit outside the named fields is zero.
    function automatic logic [EVT_WIDTH-1:0] pack_event(
        input logic [EVT_MARKER_W-1:0] marker,
        input logic [EVT_TS_W-1:0]     ts,
        input logic [EVT_SEQ_W-1:0]    seq,
        input logic [EVT_CODE_W-1:0]   code
    );
        logic [EVT_WIDTH-1:0] w;
        w = '0;
        w[EVT_CODE_LSB   +: EVT_CODE_W]   = code;
        w[EVT_SEQ_LSB    +: EVT_SEQ_W]    = seq;
        w[EVT_TS_LSB     +: EVT_TS_W]     = ts;
        w[EVT_MARKER_LSB +: EVT_MARKER_W] = marker;
        return w;
    endfunction

endpackage

// File: rtl/event_stamper_fifo.sv
// Synchronous register FIFO holding stamped events; head is read straight from storage.
module stamp_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_LEVEL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  LEVEL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == FULL_LEVEL);
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LEVEL_ONE;
                2'b01:   level_q <= level_q - LEVEL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; level/pointers decide what is visible,
    // so a reset flushes contents without paying for a wide reset tree.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/event_stamper.sv
// Stamps well-formed upstream events with a cycle timestamp and sequence number,
// queues them, and forwards them downstream; malformed cycles are dropped and counted.
module event_stamper
    import event_stamper_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [7:0] MARKER = MARKER_VALUE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [255:0]           AXIS_IN_TDATA,
    input  logic                   AXIS_IN_TVALID,
    output logic                   AXIS_IN_TREADY,
    output logic [255:0]           AXIS_OUT_TDATA,
    output logic                   AXIS_OUT_TVALID,
    input  logic                   AXIS_OUT_TREADY,
    output logic [15:0]            bad_marker_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    logic        reset_q;
    logic [63:0] ts_q;
    logic [31:0] seq_q, seq_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;

    logic        fifo_full, fifo_empty;
    logic        in_fire, marker_ok, push, pop;
    logic [EVT_WIDTH-1:0] stamped;

    // Payload bytes between code and marker are intentionally ignored.
    logic unused_tdata;
    assign unused_tdata = ^AXIS_IN_TDATA[EVT_MARKER_LSB-1:EVT_CODE_W];

    assign AXIS_IN_TREADY   = !reset_q && !fifo_full;
    assign in_fire          = AXIS_IN_TVALID && AXIS_IN_TREADY;
    assign marker_ok        = (AXIS_IN_TDATA[EVT_MARKER_LSB +: EVT_MARKER_W] == MARKER);
    assign push             = in_fire && marker_ok;
    assign AXIS_OUT_TVALID  = !fifo_empty;
    assign pop              = AXIS_OUT_TVALID && AXIS_OUT_TREADY;
    assign bad_marker_count = bad_cnt_q;

    assign stamped = pack_event(MARKER, ts_q, seq_q,
                                AXIS_IN_TDATA[EVT_CODE_LSB +: EVT_CODE_W]);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        seq_d     = seq_q;
        bad_cnt_d = bad_cnt_q;
        if (in_fire) begin
            if (marker_ok) begin
                seq_d = seq_q + 32'd1;
            end else if (bad_cnt_q != 16'hFFFF) begin
                bad_cnt_d = bad_cnt_q + 16'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        reset_q <= reset;
        if (reset) begin
            ts_q      <= '0;
            seq_q     <= '0;
            bad_cnt_q <= '0;
        end else begin
            ts_q      <= ts_q + 64'd1;
            seq_q     <= seq_d;
            bad_cnt_q <= bad_cnt_d;
        end
    end

    stamp_fifo #(
        .WIDTH (EVT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (stamped),
        .dout  (AXIS_OUT_TDATA),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_event_stamper.sv
// Scoreboard bench for event_stamper: stimulus queues expected words, a negedge monitor pops and compares.
module tb_event_stamper;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] AXIS_IN_TDATA;
    logic         AXIS_IN_TVALID;
    logic         AXIS_IN_TREADY;
    logic [255:0] AXIS_OUT_TDATA;
    logic         AXIS_OUT_TVALID;
    logic         AXIS_OUT_TREADY;
    logic [15:0]  bad_marker_count;
    logic [2:0]   fifo_level;

    always #5 clk = ~clk;

    event_stamper #(.DEPTH(4), .MARKER(8'h01)) dut (
        .clk              (clk),
        .reset            (reset),
        .AXIS_IN_TDATA    (AXIS_IN_TDATA),
        .AXIS_IN_TVALID   (AXIS_IN_TVALID),
        .AXIS_IN_TREADY   (AXIS_IN_TREADY),
        .AXIS_OUT_TDATA   (AXIS_OUT_TDATA),
        .AXIS_OUT_TVALID  (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY  (AXIS_OUT_TREADY),
        .bad_marker_count (bad_marker_count),
        .fifo_level       (fifo_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] exp_q [$];
    logic [31:0]  exp_seq;
    logic [15:0]  exp_bad;
    logic [63:0]  tb_ts;

    // Reference cycle counter: cleared by reset edges, +1 on every other edge.
    always @(posedge clk) tb_ts <= reset ? 64'd0 : tb_ts + 64'd1;

    task automatic check(input bit ok, input string name,
                         input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [255:0] exp_word(input logic [7:0] code,
                                              input logic [31:0] seq,
                                              input logic [63:0] ts);
        return {8'h01, 136'd0, ts, seq, 8'h00, code};
    endfunction

    function automatic logic [255:0] make_in(input logic [7:0] code, input logic [7:0] marker);
        logic [255:0] d;
        d = {32{8'hA5}};
        d[7:0]     = code;
        d[255:248] = marker;
        return d;
    endfunction

    // Monitor: every output handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_output", AXIS_OUT_TDATA, '0);
            end else begin
                logic [255:0] e;
                e = exp_q.pop_front();
                check(AXIS_OUT_TDATA === e, "out_data", AXIS_OUT_TDATA, e);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_seq = '0;
        exp_bad = '0;
    endtask

    // Call between a posedge and the following negedge; returns at posedge+1
    // just after the handshake edge with TVALID still asserted.
    task automatic send_event(input logic [7:0] code, input logic [7:0] marker);
        bit done;
        int waited;
        AXIS_IN_TDATA  = make_in(code, marker);
        AXIS_IN_TVALID = 1'b1;
        done   = 1'b0;
        waited = 0;
        while (!done && waited < 64) begin
            @(negedge clk);
            if (AXIS_IN_TREADY) begin
                if (marker == 8'h01) begin
                    exp_q.push_back(exp_word(code, exp_seq, tb_ts));
                    exp_seq = exp_seq + 32'd1;
                end else if (exp_bad != 16'hFFFF) begin
                    exp_bad = exp_bad + 16'd1;
                end
                done = 1'b1;
            end
            @(posedge clk); #1;
            waited++;
        end
        if (!done) check(1'b0, "in_handshake_timeout", {255'd0, AXIS_IN_TREADY}, 256'd1);
    endtask

    task automatic idle();
        AXIS_IN_TVALID = 1'b0;
        AXIS_IN_TDATA  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] head;
        reset           = 1'b1;
        AXIS_IN_TVALID  = 1'b0;
        AXIS_IN_TDATA   = '0;
        AXIS_OUT_TREADY = 1'b1;

        // Reset state and first event: accepted in the 10th cycle, timestamp 9.
        do_reset();
        @(negedge clk);
        check(AXIS_IN_TREADY == 1'b0, "rst_in_tready", {255'd0, AXIS_IN_TREADY}, '0);
        check(AXIS_OUT_TVALID == 1'b0, "rst_out_tvalid", {255'd0, AXIS_OUT_TVALID}, '0);
        check(fifo_level == 3'd0, "rst_level", {253'd0, fifo_level}, '0);
        check(bad_marker_count == 16'd0, "rst_bad_cnt", {240'd0, bad_marker_count}, '0);
        repeat (9) @(posedge clk);
        #1;
        send_event(8'h02, 8'h01);
        idle();
        @(negedge clk);
        check(AXIS_OUT_TVALID == 1'b1, "first_latency", {255'd0, AXIS_OUT_TVALID}, 256'd1);
        check(AXIS_OUT_TDATA === {8'h01, 136'd0, 64'd9, 32'd0, 8'h00, 8'h02},
              "first_word", AXIS_OUT_TDATA, {8'h01, 136'd0, 64'd9, 32'd0, 8'h00, 8'h02});

        // Three back-to-back events drain at one per cycle.
        do_reset();
        send_event(8'h01, 8'h01);
        send_event(8'h02, 8'h01);
        send_event(8'h03, 8'h01);
        idle();
        @(negedge clk);
        check(AXIS_OUT_TVALID == 1'b1, "b2b_last_valid", {255'd0, AXIS_OUT_TVALID}, 256'd1);
        @(negedge clk);
        check(AXIS_OUT_TVALID == 1'b0, "b2b_drained_valid", {255'd0, AXIS_OUT_TVALID}, '0);
        check(exp_q.size() == 0, "b2b_throughput", 256'(exp_q.size()), '0);

        // Backpressure: fill to DEPTH, head must hold, then release.
        do_reset();
        AXIS_OUT_TREADY = 1'b0;
        send_event(8'h01, 8'h01);
        send_event(8'h02, 8'h01);
        send_event(8'h03, 8'h01);
        send_event(8'h01, 8'h01);
        AXIS_IN_TDATA = make_in(8'h02, 8'h01);
        head = exp_q[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(AXIS_IN_TREADY == 1'b0, "full_in_tready", {255'd0, AXIS_IN_TREADY}, '0);
            check(fifo_level == 3'd4, "full_level", {253'd0, fifo_level}, 256'd4);
            check(AXIS_OUT_TDATA === head, "stall_head_stable", AXIS_OUT_TDATA, head);
        end
        @(posedge clk); #1;
        AXIS_OUT_TREADY = 1'b1;
        @(negedge clk);
        check(AXIS_IN_TREADY == 1'b0, "full_blocks_while_pop", {255'd0, AXIS_IN_TREADY}, '0);
        @(posedge clk); #1;
        send_event(8'h02, 8'h01);
        send_event(8'h03, 8'h01);
        idle();
        repeat (8) @(negedge clk);
        check(exp_q.size() == 0, "bp_all_emerged", 256'(exp_q.size()), '0);
        check(fifo_level == 3'd0, "bp_level_empty", {253'd0, fifo_level}, '0);

        // Malformed marker is dropped and counted; next good event keeps seq 0.
        do_reset();
        send_event(8'h02, 8'h00);
        idle();
        repeat (3) begin
            @(negedge clk);
            check(AXIS_OUT_TVALID == 1'b0, "bad_no_output", {255'd0, AXIS_OUT_TVALID}, '0);
        end
        check(bad_marker_count == 16'd1, "bad_count_one", {240'd0, bad_marker_count}, 256'd1);
        check(bad_marker_count == exp_bad, "bad_count_model", {240'd0, bad_marker_count}, {240'd0, exp_bad});
        @(posedge clk); #1;
        send_event(8'h03, 8'h01);
        idle();
        @(negedge clk);
        check(AXIS_OUT_TDATA[47:16] == 32'd0, "after_bad_seq", {224'd0, AXIS_OUT_TDATA[47:16]}, '0);

        // Reset with three entries queued flushes everything.
        do_reset();
        AXIS_OUT_TREADY = 1'b0;
        send_event(8'h01, 8'h01);
        send_event(8'h02, 8'h01);
        send_event(8'h03, 8'h01);
        idle();
        @(negedge clk);
        check(fifo_level == 3'd3, "pre_flush_level", {253'd0, fifo_level}, 256'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check(AXIS_OUT_TVALID == 1'b0, "flush_out_tvalid", {255'd0, AXIS_OUT_TVALID}, '0);
        check(fifo_level == 3'd0, "flush_level", {253'd0, fifo_level}, '0);
        check(AXIS_IN_TREADY == 1'b0, "flush_in_tready", {255'd0, AXIS_IN_TREADY}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        exp_seq = '0;
        AXIS_OUT_TREADY = 1'b1;
        send_event(8'h02, 8'h01);
        idle();
        @(negedge clk);
        check(AXIS_OUT_TVALID == 1'b1, "post_flush_valid", {255'd0, AXIS_OUT_TVALID}, 256'd1);
        check(AXIS_OUT_TDATA[47:16] == 32'd0, "post_flush_seq", {224'd0, AXIS_OUT_TDATA[47:16]}, '0);
        check(AXIS_OUT_TDATA[111:48] < 64'd16, "post_flush_small_ts",
              {192'd0, AXIS_OUT_TDATA[111:48]}, 256'd15);

        // Sequence wrap from FFFFFFFF to 0.
        @(posedge clk); #1;
        force dut.seq_q = 32'hFFFF_FFFF;
        #1;
        release dut.seq_q;
        exp_seq = 32'hFFFF_FFFF;
        send_event(8'h01, 8'h01);
        send_event(8'h03, 8'h01);
        idle();
        @(negedge clk);
        check(AXIS_OUT_TDATA[47:16] == 32'd0, "seq_wrap_zero", {224'd0, AXIS_OUT_TDATA[47:16]}, '0);

        // Bad-marker counter saturates at FFFF.
        @(posedge clk); #1;
        force dut.bad_cnt_q = 16'hFFFF;
        #1;
        release dut.bad_cnt_q;
        exp_bad = 16'hFFFF;
        send_event(8'h01, 8'h7E);
        idle();
        @(negedge clk);
        check(bad_marker_count == 16'hFFFF, "bad_count_saturate",
              {240'd0, bad_marker_count}, {240'd0, 16'hFFFF});

        repeat (4) @(negedge clk);
        check(exp_q.size() == 0, "final_scoreboard_empty", 256'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
